sram_fifo_wr_arb: RTL

SRAM_FIFO_WR_ARB -- requirements
Module: sram_fifo_wr_arb

---
 rtl/sram_fifo_wr_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sram_fifo_wr_arb.sv
// Write-side arbiter of a shared-SRAM multi-queue FIFO: round-robin, packet-locked grant
// over AXI-Stream inputs feeding a one-entry hold register toward the SRAM controller.
module sram_fifo_wr_arb #(
   parameter int TDATA_WIDTH    = 32,
   parameter int NUM_QUEUES     = 4,
   parameter int QUEUE_ID_WIDTH = 2
) (
   input  logic                                  axi_aclk,
   input  logic                                  axi_resetn,
   input  logic [NUM_QUEUES*8*TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_QUEUES*TDATA_WIDTH-1:0]     s_axis_tkeep,
   input  logic [NUM_QUEUES-1:0]                 s_axis_tlast,
   input  logic [NUM_QUEUES-1:0]                 s_axis_tvalid,
   output logic [NUM_QUEUES-1:0]                 s_axis_tready,
   output logic [8*TDATA_WIDTH+8:0]              write_data,
   output logic [QUEUE_ID_WIDTH-1:0]             write_queue_id,
   output logic                                  write_data_valid,
   input  logic [NUM_QUEUES-1:0]                 write_full,
   input  logic                                  write_burst_next,
   output logic [31:0]                           word_count,
   output logic [31:0]                           pkt_count,
   output logic                                  dbg_state_o
);

   localparam int DW = 8*TDATA_WIDTH;
   localparam int WW = DW + 9;
   localparam int QW = QUEUE_ID_WIDTH;

   typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

   state_t          state_q;
   logic [QW-1:0]   grant_q, last_grant_q, hold_qid_q;
   logic            sof_q, hold_valid_q, wr_phase_q;
   logic [WW-1:0]   hold_data_q, hold_data_d;
   logic [31:0]     word_cnt_q, pkt_cnt_q;

   logic [NUM_QUEUES-1:0]  qual, tready;
   logic                   pick_found, drain, accept, sel_full, beat_valid, beat_last;
   logic [QW-1:0]          pick;
   logic [DW-1:0]          beat_data;
   logic [TDATA_WIDTH-1:0] beat_keep;
   logic [4:0]             beat_cnt;

   // Handshake: a beat moves on s_axis when tvalid & tready at a rising edge; a word leaves
   // the hold register when it is valid, the controller's registered phase is 0 and its
   // destination queue is not full.
   always_comb begin : drain_logic
      sel_full = 1'b0;
      for (int p = 0; p < NUM_QUEUES; p++)
         if (hold_qid_q == p[QW-1:0]) sel_full = write_full[p];
      drain = hold_valid_q & ~wr_phase_q & ~sel_full;
   end

   always_comb begin : beat_mux
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      beat_data  = '0;
      beat_keep  = '0;
      for (int p = 0; p < NUM_QUEUES; p++) begin
         if (grant_q == p[QW-1:0]) begin
            beat_valid = s_axis_tvalid[p];
            beat_last  = s_axis_tlast[p];
            beat_data  = s_axis_tdata[p*DW +: DW];
            beat_keep  = s_axis_tkeep[p*TDATA_WIDTH +: TDATA_WIDTH];
         end
      end
      // Only the EOF beat carries a real byte count; full beats report 31.
      beat_cnt = 5'd31;
      if (beat_last)
         for (int i = 0; i < TDATA_WIDTH; i++)
            if (beat_keep[i]) beat_cnt = i[4:0];
      hold_data_d = {1'b0, beat_last, sof_q, 1'b0, beat_cnt, beat_data};
   end

   always_comb begin : ready_logic
      tready = '0;
      if (state_q == PKT)
         for (int p = 0; p < NUM_QUEUES; p++)
            if (grant_q == p[QW-1:0]) tready[p] = ~hold_valid_q | drain;
      accept = (state_q == PKT) & beat_valid & (~hold_valid_q | drain);
   end

   always_comb begin : rr_pick
      int idx;
      qual       = s_axis_tvalid & ~write_full;
      pick_found = 1'b0;
      pick       = '0;
      idx        = 0;
      for (int k = 1; k <= NUM_QUEUES; k++) begin
         idx = (int'(last_grant_q) + k) % NUM_QUEUES;
         if (!pick_found && qual[idx[QW-1:0]]) begin
            pick_found = 1'b1;
            pick       = idx[QW-1:0];
         end
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= QW'(NUM_QUEUES - 1);
         sof_q        <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_qid_q   <= '0;
         wr_phase_q   <= 1'b0;
         word_cnt_q   <= '0;
         pkt_cnt_q    <= '0;
      end else begin
         wr_phase_q <= write_burst_next;
         if (drain) begin
            word_cnt_q <= word_cnt_q + 32'd1;
            if (hold_data_q[DW+7]) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         if (accept) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= hold_data_d;
            hold_qid_q   <= grant_q;
         end else if (drain) begin
            hold_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q <= PKT;
                  grant_q <= pick;
                  sof_q   <= 1'b1;
               end
            end
            PKT: begin
               // Grant stays locked until the tlast beat is taken.
               if (accept) begin
                  sof_q <= 1'b0;
                  if (beat_last) begin
                     state_q      <= IDLE;
                     last_grant_q <= grant_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_axis_tready    = tready;
   assign write_data       = hold_data_q;
   assign write_queue_id   = hold_qid_q;
   assign write_data_valid = hold_valid_q;
   assign word_count       = word_cnt_q;
   assign pkt_count        = pkt_cnt_q;
   assign dbg_state_o      = state_q;

endmodule
